regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port (write enable, write address, write data) between two writeback requesters.
  - Port 0: single-cycle ALU pipe.
  - Port 1: long-latency unit (load/mul/div).
- Keeps a per-register busy scoreboard for long-latency destinations and exposes hazard flags for the two read addresses.
- Sits between the execute/writeback stages and the register file.
- Its output register drives the register file write port directly.

Parameters:
- XLEN, 32, data width of writeback data and register-file write data.
- NREG, 32, number of architectural registers; register addresses are $clog2(NREG) bits (5 at default); register 0 is hardwired zero.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb0_valid_i  in  1  port 0 writeback request.
- wb0_rd_i  in  5  port 0 destination register.
- wb0_data_i  in  XLEN  port 0 data.
- wb0_ready_o  out  1  port 0 granted this cycle.
- wb1_valid_i  in  1  port 1 writeback request.
- wb1_rd_i  in  5  port 1 destination register.
- wb1_data_i  in  XLEN  port 1 data.
- wb1_ready_o  out  1  port 1 granted this cycle.
- issue_valid_i  in  1  long-latency op issued this cycle.
- issue_rd_i  in  5  its destination register.
- issue_ready_o  out  1  issue may be accepted.
- rs1_i  in  5  read address 1, for the hazard check.
- rs2_i  in  5  read address 2, for the hazard check.
- rs1_busy_o  out  1  rs1 value is not yet valid in the register file.
- rs2_busy_o  out  1  rs2 value is not yet valid in the register file.
- rf_we_o  out  1  register file write enable.
- rf_rd_o  out  5  register file write address.
- rf_data_o  out  XLEN  register file write data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_i high):
  - rf_we_o=0, rf_rd_o=0, rf_data_o=0, err_o=0.
  - All busy bits cleared.
  - Round-robin pointer set so that port 0 wins the first contention.
  - An in-flight output write is discarded immediately; rf_we_o falls without waiting for a clock edge.
- Arbitration (combinational from valids and pointer):
  - Exactly one valid: that port is granted.
  - Both valid: grant the port not granted at the last contention, then flip the pointer.
  - Pointer updates only on contention cycles.
  - wbN_ready_o = grant for N; a handshake is valid && ready.
  - The output stage always drains, so ready is never low because of backpressure.
- Output stage: a write accepted at edge N appears on rf_* for cycle N+1. The register file writes it at edge N+1, so latency from handshake to register-file contents is 2 edges.
- Register 0:
  - A handshake with rd=0 is accepted and consumed, but rf_we_o stays 0 for it.
  - issue_rd_i=0 never sets a busy bit.
  - rs=0 never reports busy.
- Scoreboard, busy[NREG-1:1]:
  - Set at the edge where issue_valid_i && issue_ready_o && issue_rd_i!=0.
  - Cleared at the edge where rf_we_o=1, the source of that output entry was port 1, and rf_rd_o matches.
  - Port 0 writes never clear busy bits.
- issue_ready_o = !busy[issue_rd_i]. WAW on a long-latency destination therefore stalls issue. This also removes any same-cycle set/clear conflict on one register.
- rsN_busy_o = (rsN!=0) && (busy[rsN] || (rf_we_o && rf_rd_o==rsN)). The second term covers the write still in flight in the output register.
- err_o is set and held until reset when either of these occurs:
  - a port 1 handshake targets a register that is not busy (rd!=0);
  - issue_valid_i is asserted while issue_ready_o=0.
- An erroneous port 1 write is still performed.
- An issue asserted while issue_ready_o=0 is ignored; no state changes.
- Valid/data held by a requester while not granted must stay stable; the scheduler takes no action on a dropped request.

Test Plan:
1. Assert rst_i mid-cycle while rf_we_o=1 -> rf_we_o, rf_rd_o, rf_data_o, busy and err_o all 0 immediately.
2. Single port 0 handshake at edge N, rd=5, data=0xDEADBEEF -> in cycle N+1: rf_we_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF, and rs1_i=5 gives rs1_busy_o=1 -> in cycle N+2: rs1_busy_o=0 and register 5 reads 0xDEADBEEF.
3. Both ports valid for 4 cycles with rd=1..4 -> grants alternate 0,1,0,1 (port 0 first after reset); rf_rd_o follows the grant order one cycle later; no request is lost.
4. Issue rd=7 -> rs2_i=7 gives rs2_busy_o=1, and issue_ready_o=0 for issue_rd_i=7 -> port 1 writes rd=7, data=0x12345678 -> rs2_busy_o stays 1 through the rf_we_o cycle and drops the cycle after.
5. Port 0 handshake with rd=0, and issue with rd=0 -> wb0_ready_o=1, rf_we_o stays 0, no busy bit set, rs1_i=0 gives busy 0.
6. Port 1 write to non-busy rd=9 -> the write is performed and err_o=1, staying 1 until reset. Issue to busy rd=7 -> err_o=1 and busy/pointer state unchanged.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration between the ALU
// and long-latency writeback ports, a registered write stage, and a busy scoreboard.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb0_valid_i,
    input  logic [$clog2(NREG)-1:0] wb0_rd_i,
    input  logic [XLEN-1:0]         wb0_data_i,
    output logic                    wb0_ready_o,
    input  logic                    wb1_valid_i,
    input  logic [$clog2(NREG)-1:0] wb1_rd_i,
    input  logic [XLEN-1:0]         wb1_data_i,
    output logic                    wb1_ready_o,
    input  logic                    issue_valid_i,
    input  logic [$clog2(NREG)-1:0] issue_rd_i,
    output logic                    issue_ready_o,
    input  logic [$clog2(NREG)-1:0] rs1_i,
    input  logic [$clog2(NREG)-1:0] rs2_i,
    output logic                    rs1_busy_o,
    output logic                    rs2_busy_o,
    output logic                    rf_we_o,
    output logic [$clog2(NREG)-1:0] rf_rd_o,
    output logic [XLEN-1:0]         rf_data_o,
    output logic                    err_o
);
    localparam int AW = $clog2(NREG);

    logic            prio1_q, prio1_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            src1_q, src1_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;

    // prio1_q: port 1 wins the next contention (cleared so port 0 wins first)
    always_comb begin
        wb0_ready_o = wb0_valid_i && (!wb1_valid_i || !prio1_q);
        wb1_ready_o = wb1_valid_i && (!wb0_valid_i || prio1_q);
        prio1_d     = prio1_q;
        if (wb0_valid_i && wb1_valid_i) begin
            prio1_d = !prio1_q;
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        src1_d    = src1_q;
        if (wb0_ready_o) begin
            rf_we_d   = (wb0_rd_i != '0);
            rf_rd_d   = wb0_rd_i;
            rf_data_d = wb0_data_i;
            src1_d    = 1'b0;
        end else if (wb1_ready_o) begin
            rf_we_d   = (wb1_rd_i != '0);
            rf_rd_d   = wb1_rd_i;
            rf_data_d = wb1_data_i;
            src1_d    = 1'b1;
        end
    end

    assign issue_ready_o = !busy_q[issue_rd_i];

    // A busy destination blocks issue, so set and clear never hit the same bit.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && src1_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (issue_valid_i && issue_ready_o && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q;
        if (wb1_ready_o && (wb1_rd_i != '0) && !busy_q[wb1_rd_i]) begin
            err_d = 1'b1;
        end
        if (issue_valid_i && !issue_ready_o) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio1_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            src1_q    <= 1'b0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            prio1_q   <= prio1_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            src1_q    <= src1_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // In-flight write counts as busy until the register file has absorbed it.
    assign rs1_busy_o = (rs1_i != '0) && (busy_q[rs1_i] || (rf_we_q && (rf_rd_q == rs1_i)));
    assign rs2_busy_o = (rs2_i != '0) && (busy_q[rs2_i] || (rf_we_q && (rf_rd_q == rs2_i)));

    assign rf_we_o   = rf_we_q;
    assign rf_rd_o   = rf_rd_q;
    assign rf_data_o = rf_data_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_regfile_wb_scheduler;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic        clk, rst;
    logic        v0, v1, iv;
    logic [4:0]  rd0, rd1, ird, rs1, rs2;
    logic [31:0] d0, d1;
    logic        wb0_ready_o, wb1_ready_o, issue_ready_o;
    logic        rs1_busy_o, rs2_busy_o, rf_we_o, err_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;

    int n_chk = 0;
    int n_fail = 0;

    regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb0_valid_i(v0), .wb0_rd_i(rd0), .wb0_data_i(d0), .wb0_ready_o(wb0_ready_o),
        .wb1_valid_i(v1), .wb1_rd_i(rd1), .wb1_data_i(d1), .wb1_ready_o(wb1_ready_o),
        .issue_valid_i(iv), .issue_rd_i(ird), .issue_ready_o(issue_ready_o),
        .rs1_i(rs1), .rs2_i(rs2), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy[NREG];
    bit          ob[NREG];
    bit          m_p1_next;
    bit          m_we, m_src1, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic bit e_g0();
        return v0 && (!v1 || !m_p1_next);
    endfunction
    function automatic bit e_g1();
        return v1 && (!v0 || m_p1_next);
    endfunction
    function automatic bit e_rsb(input logic [4:0] rs);
        return (rs != 0) && (m_busy[rs] || (m_we && m_rd == rs));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            m_p1_next = 1'b0;
            m_we = 1'b0; m_src1 = 1'b0; m_err = 1'b0;
            m_rd = '0; m_data = '0;
        end else begin
            bit g0, g1;
            g0 = e_g0();
            g1 = e_g1();
            ob = m_busy;
            if (m_we && m_src1) m_busy[m_rd] = 1'b0;
            if (g1 && rd1 != 0 && !ob[rd1]) m_err = 1'b1;
            if (iv && ob[ird]) m_err = 1'b1;
            if (iv && !ob[ird] && ird != 0) m_busy[ird] = 1'b1;
            if (v0 && v1) m_p1_next = g0;
            if (g0 || g1) begin
                m_rd   = g0 ? rd0 : rd1;
                m_data = g0 ? d0 : d1;
                m_we   = (m_rd != 0);
                m_src1 = g1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("wb0_ready", {31'b0, wb0_ready_o}, {31'b0, e_g0()});
        chk("wb1_ready", {31'b0, wb1_ready_o}, {31'b0, e_g1()});
        chk("issue_ready", {31'b0, issue_ready_o}, {31'b0, !m_busy[ird]});
        chk("rs1_busy", {31'b0, rs1_busy_o}, {31'b0, e_rsb(rs1)});
        chk("rs2_busy", {31'b0, rs2_busy_o}, {31'b0, e_rsb(rs2)});
        chk("rf_we", {31'b0, rf_we_o}, {31'b0, m_we});
        chk("err", {31'b0, err_o}, {31'b0, m_err});
        if (m_we) begin
            chk("rf_rd", {27'b0, rf_rd_o}, {27'b0, m_rd});
            chk("rf_data", rf_data_o, m_data);
        end
    end

    // Register file driven by the DUT write port
    logic [31:0] brf[NREG];
    always @(posedge clk) if (rf_we_o) brf[rf_rd_o] <= rf_data_o;

    bit   rec = 1'b0;
    int   rq[$];
    int   cq[$];
    always @(negedge clk) if (rec && rf_we_o) rq.push_back(int'(rf_rd_o));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; iv = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0[3];
        int l1[2];
        int i0, i1, cyc;
        bit g0, g1;
        l0 = '{1, 3, 5};
        l1 = '{2, 4};
        rst = 1; idle();
        rd0 = 0; rd1 = 0; ird = 0; rs1 = 0; rs2 = 0; d0 = 0; d1 = 0;
        #2;
        chk("reset_rf_we", {31'b0, rf_we_o}, 32'd0);
        chk("reset_err", {31'b0, err_o}, 32'd0);
        tick(); tick();
        rst = 0;

        // single port-0 write, rd=5
        v0 = 1; rd0 = 5; d0 = 32'hDEADBEEF; rs1 = 5;
        tick();
        idle();
        #2;
        chk("t2_we", {31'b0, rf_we_o}, 32'd1);
        chk("t2_rd", {27'b0, rf_rd_o}, 32'd5);
        chk("t2_data", rf_data_o, 32'hDEADBEEF);
        chk("t2_rs1_busy", {31'b0, rs1_busy_o}, 32'd1);
        tick();
        #2;
        chk("t2_rs1_clear", {31'b0, rs1_busy_o}, 32'd0);
        chk("t2_rf5", brf[5], 32'hDEADBEEF);

        // register 0 handling
        v0 = 1; rd0 = 0; d0 = 32'h55; iv = 1; ird = 0; rs1 = 0;
        #2;
        chk("t5_wb0_ready", {31'b0, wb0_ready_o}, 32'd1);
        chk("t5_issue_ready", {31'b0, issue_ready_o}, 32'd1);
        tick();
        idle();
        #2;
        chk("t5_we", {31'b0, rf_we_o}, 32'd0);
        chk("t5_rs1_busy", {31'b0, rs1_busy_o}, 32'd0);
        chk("t5_issue_ready0", {31'b0, issue_ready_o}, 32'd1);

        // long-latency rd=7
        iv = 1; ird = 7; rs2 = 7;
        tick();
        iv = 0;
        #2;
        chk("t4_rs2_busy", {31'b0, rs2_busy_o}, 32'd1);
        chk("t4_issue_ready", {31'b0, issue_ready_o}, 32'd0);
        v1 = 1; rd1 = 7; d1 = 32'h12345678;
        tick();
        v1 = 0;
        #2;
        chk("t4_we", {31'b0, rf_we_o}, 32'd1);
        chk("t4_rs2_inflight", {31'b0, rs2_busy_o}, 32'd1);
        tick();
        #2;
        chk("t4_rs2_clear", {31'b0, rs2_busy_o}, 32'd0);
        chk("t4_rf7", brf[7], 32'h12345678);
        chk("t4_err", {31'b0, err_o}, 32'd0);

        // contention: port 0 rd 1,3,5 vs port 1 rd 2,4
        iv = 1; ird = 2; tick();
        ird = 4; tick();
        iv = 0; ird = 0; rs2 = 0;
        i0 = 0; i1 = 0; cyc = 0; rec = 1;
        while ((i0 < 3 || i1 < 2) && cyc < 12) begin
            v0 = (i0 < 3);
            rd0 = v0 ? 5'(l0[i0]) : 5'd0;
            d0 = 32'hA000_0000 | 32'(rd0);
            v1 = (i1 < 2);
            rd1 = v1 ? 5'(l1[i1]) : 5'd0;
            d1 = 32'hA000_0000 | 32'(rd1);
            #2;
            g0 = wb0_ready_o; g1 = wb1_ready_o;
            if (v0 && v1) cq.push_back(g1 ? 1 : 0);
            tick();
            if (g0) i0++;
            if (g1) i1++;
            cyc++;
        end
        idle();
        chk("t3_all_granted", {31'b0, (i0 == 3 && i1 == 2)}, 32'd1);
        tick(); tick();
        rec = 0;
        chk("t3_ncont", cq.size(), 32'd4);
        for (int k = 0; k < 4 && k < cq.size(); k++)
            chk("t3_grant_order", cq[k], k % 2);
        chk("t3_nwrites", rq.size(), 32'd5);
        for (int k = 0; k < 5 && k < rq.size(); k++)
            chk("t3_write_order", rq[k], k + 1);
        chk("t3_rf2", brf[2], 32'hA000_0002);
        chk("t3_rf4", brf[4], 32'hA000_0004);
        rs1 = 2; rs2 = 4;
        #2;
        chk("t3_rs1_clear", {31'b0, rs1_busy_o}, 32'd0);
        chk("t3_rs2_clear", {31'b0, rs2_busy_o}, 32'd0);
        chk("t3_err", {31'b0, err_o}, 32'd0);
        tick();
        rs1 = 0; rs2 = 0;

        // port-1 write to a non-busy register
        v1 = 1; rd1 = 9; d1 = 32'h9999_0009;
        tick();
        v1 = 0;
        #2;
        chk("t6_we", {31'b0, rf_we_o}, 32'd1);
        tick();
        #2;
        chk("t6_err", {31'b0, err_o}, 32'd1);
        chk("t6_rf9", brf[9], 32'h9999_0009);
        tick(); tick();
        chk("t6_err_sticky", {31'b0, err_o}, 32'd1);

        // mid-cycle reset with a write in flight and a busy register
        iv = 1; ird = 12; tick();
        iv = 0; ird = 0;
        v0 = 1; rd0 = 11; d0 = 32'h0000_0B0B;
        tick();
        idle();
        rs1 = 12;
        #2;
        chk("t1_pre_we", {31'b0, rf_we_o}, 32'd1);
        chk("t1_pre_busy", {31'b0, rs1_busy_o}, 32'd1);
        rst = 1;
        #1;
        chk("t1_we", {31'b0, rf_we_o}, 32'd0);
        chk("t1_rd", {27'b0, rf_rd_o}, 32'd0);
        chk("t1_data", rf_data_o, 32'd0);
        chk("t1_err", {31'b0, err_o}, 32'd0);
        chk("t1_busy", {31'b0, rs1_busy_o}, 32'd0);
        tick(); tick();
        rst = 0; rs1 = 0;

        // issue to a busy register is an error and is ignored
        iv = 1; ird = 7; rs2 = 7;
        tick();
        #2;
        chk("t6b_issue_ready", {31'b0, issue_ready_o}, 32'd0);
        tick();
        iv = 0;
        #2;
        chk("t6b_err", {31'b0, err_o}, 32'd1);
        chk("t6b_rs2_busy", {31'b0, rs2_busy_o}, 32'd1);
        v0 = 1; rd0 = 3; d0 = 32'h33; v1 = 1; rd1 = 7; d1 = 32'h77;
        #2;
        chk("t6b_ptr_p0", {31'b0, wb0_ready_o}, 32'd1);
        tick();
        v0 = 0;
        tick();
        v1 = 0;
        tick(); tick();
        chk("t6b_rf7", brf[7], 32'h77);
        chk("t6b_err_sticky", {31'b0, err_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
